uart_tx_fifo: RTL

Parametrised, buffered UART transmitter: the successor to the team's fixed 8N1 transmitter. Accepts words from the host side into an internal FIFO and serialises them back-to-back on `uart_txd`. It supports configurable data width, stop-bit count and an optional compiled-in parity bit. Runs entirely in the baud clock domain `tx_clk`, one clock per bit, driven by the existing baud clock generator.

---
 rtl/uart_tx_fifo_if.sv | 23 ++
 rtl/uart_tx_fifo.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - host write port, serial line and status signals of uart_tx_fifo
interface uart_tx_fifo_if #(
  parameter int DATA_BW = 8,
  parameter int FIFO_AW = 4
);
  logic               tx_en;
  logic [DATA_BW-1:0] tx_data;
  logic               tx_rdy;
  logic               uart_txd;
  logic               tx_busy;
  logic [FIFO_AW:0]   fifo_level;
  logic               tx_ovf;

  modport master (
    output tx_en, tx_data,
    input  tx_rdy, uart_txd, tx_busy, fifo_level, tx_ovf
  );

  modport slave (
    input  tx_en, tx_data,
    output tx_rdy, uart_txd, tx_busy, fifo_level, tx_ovf
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter, one tx_clk per bit
// Optional parity bit compiled in with `define UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int DATA_BW    = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_AW    = 4,
  parameter bit PARITY_ODD = 1'b0
) (
  input logic           tx_clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);
  localparam int               IDX_W    = $clog2(DATA_BW);
  localparam logic [FIFO_AW:0] DEPTH    = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BW - 1);
  localparam logic [1:0]       STOP_END = 2'(STOP_BITS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
`ifdef UART_TX_PARITY_EN
    PARITY = 2'd2,
`endif
    STOP   = 2'd3
  } state_t;

`ifndef UART_TX_PARITY_EN
  localparam bit parity_odd_unused = PARITY_ODD;
`endif

  logic [DATA_BW-1:0] mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   level;
  logic               ovf;
  logic               rdy;
  logic               wr;
  logic               pop;

  state_t             state;
  state_t             state_n;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_n;
  logic [1:0]         stop_cnt;
  logic [1:0]         stop_cnt_n;
  logic [DATA_BW-1:0] shreg;
  logic [DATA_BW-1:0] shreg_n;
  logic               txd;
  logic               txd_n;
  logic               busy;
  logic               busy_n;
  logic               start;

  assign rdy = (level != DEPTH);
  assign wr  = bus.tx_en && rdy;

  always_ff @(posedge tx_clk) begin
    if (wr) begin
      mem[wr_ptr] <= bus.tx_data;
    end
  end

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({wr, pop})
        2'b10:   level <= level + (FIFO_AW+1)'(1);
        2'b01:   level <= level - (FIFO_AW+1)'(1);
        default: level <= level;
      endcase
      if (bus.tx_en && !rdy) begin
        ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      stop_cnt <= '0;
      shreg    <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      stop_cnt <= stop_cnt_n;
      shreg    <= shreg_n;
      txd      <= txd_n;
      busy     <= busy_n;
    end
  end

  // Registered txd: each edge drives the bit that will be on the line for the next cycle.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    stop_cnt_n = stop_cnt;
    shreg_n    = shreg;
    txd_n      = txd;
    busy_n     = busy;
    start      = 1'b0;
    case (state)
      IDLE: begin
        txd_n  = 1'b1;
        busy_n = 1'b0;
        start  = (level != '0);
      end
      DATA: begin
        txd_n = shreg[idx];
        if (idx == LAST_IDX) begin
          stop_cnt_n = '0;
`ifdef UART_TX_PARITY_EN
          state_n    = PARITY;
`else
          state_n    = STOP;
`endif
        end else begin
          idx_n = idx + IDX_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        txd_n      = (^shreg) ^ PARITY_ODD;
        stop_cnt_n = '0;
        state_n    = STOP;
      end
`endif
      STOP: begin
        if (stop_cnt == STOP_END) begin
          // Edge ending the last stop bit: chain straight into the next start bit.
          start = (level != '0);
          if (level == '0) begin
            txd_n   = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end else begin
          txd_n      = 1'b1;
          stop_cnt_n = stop_cnt + 2'd1;
        end
      end
      default: begin
        txd_n   = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
    pop = start;
    if (start) begin
      shreg_n = mem[rd_ptr];
      txd_n   = 1'b0;
      busy_n  = 1'b1;
      idx_n   = '0;
      state_n = DATA;
    end
  end

  assign bus.tx_rdy     = rdy;
  assign bus.uart_txd   = txd;
  assign bus.tx_busy    = busy;
  assign bus.fifo_level = level;
  assign bus.tx_ovf     = ovf;
endmodule
